// File: rtl/sdf_butterfly_stage_pkg.sv
// Shared constants and helpers for the radix-2 single-path
// delay-feedback butterfly stage.
package sdf_butterfly_stage_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 4;

  // Sample counter spans one block of 2*DEPTH samples.
  function automatic int cnt_width(input int depth);
    return (depth < 1) ? 1 : $clog2(2 * depth);
  endfunction

endpackage

// File: rtl/sdf_butterfly_stage_if.sv
// Streaming sample bus: qualified complex input,
// qualified complex output.
interface sdf_butterfly_stage_if
  import sdf_butterfly_stage_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             in_en;
  logic [WIDTH-1:0] in_re;
  logic [WIDTH-1:0] in_im;
  logic             out_en;
  logic [WIDTH-1:0] out_re;
  logic [WIDTH-1:0] out_im;

  modport master (
    output in_en,
    output in_re,
    output in_im,
    input  out_en,
    input  out_re,
    input  out_im
  );

  modport slave (
    input  in_en,
    input  in_re,
    input  in_im,
    output out_en,
    output out_re,
    output out_im
  );

endinterface

// File: rtl/sdf_delay_line.sv
// DEPTH-entry complex shift FIFO; head is the sample
// written DEPTH shifts ago. Data is deliberately unreset.
module sdf_delay_line
  import sdf_butterfly_stage_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clock,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_re,
  input  logic [WIDTH-1:0] i_im,
  output logic [WIDTH-1:0] o_head_re,
  output logic [WIDTH-1:0] o_head_im
);

  logic [WIDTH-1:0] r_re [DEPTH];
  logic [WIDTH-1:0] r_im [DEPTH];

  always_ff @(posedge clock) begin
    if (i_shift) begin
      r_re[0] <= i_re;
      r_im[0] <= i_im;
      for (int i = 1; i < DEPTH; i++) begin
        r_re[i] <= r_re[i-1];
        r_im[i] <= r_im[i-1];
      end
    end
  end

  assign o_head_re = r_re[DEPTH-1];
  assign o_head_im = r_im[DEPTH-1];

endmodule

// File: rtl/sdf_butterfly_stage.sv
// Radix-2 SDF butterfly: fill half stores inputs, compute
// half emits a+b and recirculates a-b for the next block.
module sdf_butterfly_stage
  import sdf_butterfly_stage_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                 clock,
  input  logic                 reset,
  sdf_butterfly_stage_if.slave bus
);

  localparam int CW = cnt_width(DEPTH);
  localparam logic [CW-1:0] LAST = CW'(2 * DEPTH - 1);

  logic [CW-1:0]    r_cnt;
  logic             r_primed;
  logic             r_out_en;
  logic [WIDTH-1:0] r_out_re;
  logic [WIDTH-1:0] r_out_im;

  logic             w_phase;
  logic             w_emit;
  logic [WIDTH-1:0] w_head_re;
  logic [WIDTH-1:0] w_head_im;
  logic [WIDTH-1:0] w_sum_re;
  logic [WIDTH-1:0] w_sum_im;
  logic [WIDTH-1:0] w_dif_re;
  logic [WIDTH-1:0] w_dif_im;
  logic [WIDTH-1:0] w_line_re;
  logic [WIDTH-1:0] w_line_im;

  assign w_phase = r_cnt[CW-1];
  assign w_emit  = w_phase | r_primed;

  // Modulo arithmetic: sums simply wrap at WIDTH bits.
  assign w_sum_re = w_head_re + bus.in_re;
  assign w_sum_im = w_head_im + bus.in_im;
  assign w_dif_re = w_head_re - bus.in_re;
  assign w_dif_im = w_head_im - bus.in_im;

  assign w_line_re = w_phase ? w_dif_re : bus.in_re;
  assign w_line_im = w_phase ? w_dif_im : bus.in_im;

  sdf_delay_line #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_line (
    .clock     (clock),
    .i_shift   (bus.in_en),
    .i_re      (w_line_re),
    .i_im      (w_line_im),
    .o_head_re (w_head_re),
    .o_head_im (w_head_im)
  );

  // Block length is a power of two, so the counter wraps
  // naturally from LAST back to zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_primed <= 1'b0;
      r_out_en <= 1'b0;
      r_out_re <= '0;
      r_out_im <= '0;
    end else begin
      r_out_en <= 1'b0;
      if (bus.in_en) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == LAST)
          r_primed <= 1'b1;
        r_out_en <= w_emit;
        if (w_emit) begin
          r_out_re <= w_phase ? w_sum_re : w_head_re;
          r_out_im <= w_phase ? w_sum_im : w_head_im;
        end
      end
    end
  end

  assign bus.out_en = r_out_en;
  assign bus.out_re = r_out_re;
  assign bus.out_im = r_out_im;

endmodule

// File: tb/tb_sdf_butterfly_stage.sv
// Bench for sdf_butterfly_stage: vector tables feed a
// cycle-stamped scoreboard checked on the falling edge.
module tb_sdf_butterfly_stage;
  import sdf_butterfly_stage_pkg::*;

  localparam int W = 16;
  localparam int D = 4;

  typedef struct {
    logic [W-1:0] re;
    logic [W-1:0] im;
    bit           ev;
    logic [W-1:0] ere;
    logic [W-1:0] eim;
  } vec_t;

  typedef struct {
    logic [W-1:0] re;
    logic [W-1:0] im;
    int           due;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  exp_t sbq[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc = cyc + 1;

  sdf_butterfly_stage_if #(.WIDTH(W)) bus ();

  sdf_butterfly_stage #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Every output must land exactly on its due cycle.
  always @(negedge clock) begin
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      checks++;
      if (!(bus.out_en === 1'b1 && bus.out_re === sbq[0].re
            && bus.out_im === sbq[0].im)) begin
        fails++;
        $display("FAIL sb_out cyc=%0d got en=%b re=%h im=%h want en=1 re=%h im=%h",
                 cyc, bus.out_en, bus.out_re, bus.out_im,
                 sbq[0].re, sbq[0].im);
      end
      void'(sbq.pop_front());
    end else begin
      checks++;
      if (bus.out_en !== 1'b0) begin
        fails++;
        $display("FAIL sb_idle cyc=%0d got en=%b want en=0",
                 cyc, bus.out_en);
      end
    end
  end

  function automatic vec_t mk(input logic [W-1:0] re,
                              input logic [W-1:0] im,
                              input bit ev,
                              input logic [W-1:0] ere,
                              input logic [W-1:0] eim);
    vec_t v;
    v.re = re; v.im = im; v.ev = ev;
    v.ere = ere; v.eim = eim;
    return v;
  endfunction

  task automatic check(input string nm,
                       input logic [W-1:0] got,
                       input logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic run(input vec_t v[$], input int gap);
    foreach (v[k]) begin
      @(negedge clock);
      bus.in_en = 1'b1;
      bus.in_re = v[k].re;
      bus.in_im = v[k].im;
      if (v[k].ev) begin
        exp_t e;
        e.re = v[k].ere; e.im = v[k].eim; e.due = cyc + 1;
        sbq.push_back(e);
      end
      for (int g = 0; g < gap; g++) begin
        @(negedge clock);
        bus.in_en = 1'b0;
        bus.in_re = 16'hA5A5;
        bus.in_im = 16'h5A5A;
        if (g > 0) begin
          check("gap_en", W'(bus.out_en), '0);
          if (v[k].ev) begin
            check("gap_hold_re", bus.out_re, v[k].ere);
            check("gap_hold_im", bus.out_im, v[k].eim);
          end
        end
      end
    end
    @(negedge clock);
    bus.in_en = 1'b0;
  endtask

  task automatic drain(input string nm);
    repeat (3) @(negedge clock);
    checks++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL %s pending=%0d want=0", nm, sbq.size());
      sbq.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    #2;
    bus.in_en = 1'b0;
    reset = 1'b1;
    sbq.delete();
    #1;
    check("rst_en", W'(bus.out_en), '0);
    check("rst_re", bus.out_re, '0);
    check("rst_im", bus.out_im, '0);
    @(negedge clock);
    #2;
    reset = 1'b0;
  endtask

  vec_t basic[$];
  vec_t wrapv[$];
  vec_t cplx[$];
  vec_t part[$];
  vec_t prime[$];

  initial begin
    logic [W-1:0] bi  [8];
    logic [W-1:0] bc  [4];
    logic [W-1:0] bd  [4];
    bi = '{16'd1, 16'd2, 16'd3, 16'd4,
           16'd10, 16'd20, 16'd30, 16'd40};
    bc = '{16'd11, 16'd22, 16'd33, 16'd44};
    bd = '{16'hFFF7, 16'hFFEE, 16'hFFE5, 16'hFFDC};
    for (int i = 0; i < 4; i++)
      basic.push_back(mk(bi[i], '0, 1'b0, '0, '0));
    for (int i = 0; i < 4; i++)
      basic.push_back(mk(bi[i+4], '0, 1'b1, bc[i], '0));
    for (int i = 0; i < 4; i++)
      basic.push_back(mk('0, '0, 1'b1, bd[i], '0));
    for (int i = 0; i < 4; i++)
      wrapv.push_back(mk(16'h7FFF, '0, 1'b0, '0, '0));
    for (int i = 0; i < 4; i++)
      wrapv.push_back(mk(16'h0001, '0, 1'b1, 16'h8000, '0));
    for (int i = 0; i < 4; i++)
      wrapv.push_back(mk('0, '0, 1'b1, 16'h7FFE, '0));
    for (int i = 0; i < 4; i++)
      cplx.push_back(mk(16'd1, 16'd2, 1'b0, '0, '0));
    for (int i = 0; i < 4; i++)
      cplx.push_back(mk(16'd3, 16'hFFFB, 1'b1, 16'd4, 16'hFFFD));
    for (int i = 0; i < 4; i++)
      cplx.push_back(mk('0, '0, 1'b1, 16'hFFFE, 16'd7));
    for (int i = 0; i < 6; i++)
      part.push_back(basic[i]);
    for (int i = 0; i < 4; i++)
      prime.push_back(mk(16'd100 + 16'(i), 16'd9, 1'b0, '0, '0));

    bus.in_en = 1'b0;
    bus.in_re = '0;
    bus.in_im = '0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check("init_en", W'(bus.out_en), '0);
    check("init_re", bus.out_re, '0);
    check("init_im", bus.out_im, '0);
    #2;
    reset = 1'b0;

    run(basic, 0);
    drain("basic_drain");

    do_reset();
    run(basic, 3);
    drain("gaps_drain");

    do_reset();
    run(wrapv, 0);
    drain("wrap_drain");

    do_reset();
    run(cplx, 1);
    drain("cplx_drain");

    do_reset();
    run(part, 0);
    drain("part_drain");
    do_reset();
    run(basic, 0);
    drain("midrst_drain");

    do_reset();
    run(prime, 2);
    repeat (6) @(negedge clock);
    drain("prime_drain");

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
